ssd_bcd_counter_mux: RTL and testbench

Parametrised multi-digit BCD up/down counter driving a time-multiplexed, common-anode seven-segment display. It extends the single-digit free-running counter/decoder with a configurable digit count, a tick prescaler, count direction, enable, synchronous clear, a wrap flag and digit scanning. It sits between the board clock/reset and the display pins.

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/ssd_decoder.sv | 28 ++
 rtl/ssd_bcd_counter_mux.sv | 198 +++++++++++++++++++
 tb/tb_ssd_bcd_counter_mux.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and segment constants for the multiplexed BCD display counter.
// Segment order is {g,f,e,d,c,b,a}, active-low (common-anode display).
package ssd_pkg;

  // One BCD digit; legal values are 0..9.
  typedef logic [3:0] bcd_digit_t;

  // Active-low segment vector {g,f,e,d,c,b,a}.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_ERR   = 7'b0000110;  // 'E' for non-BCD codes
  localparam seg_t SEG_BLANK = 7'b1111111;  // all segments off

endpackage

// File: rtl/ssd_decoder.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
// Codes 10..15 cannot occur from the counter but still decode to 'E'.
module ssd_decoder
  import ssd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output seg_t       o_seg
);

  // Digit lookup; default covers the non-BCD codes.
  always_comb begin
    o_seg = SEG_ERR;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/ssd_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with prescaler, wrap pulse and a
// time-multiplexed common-anode seven-segment display driver.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is never blanked); it only changes o_count_ssd.
module ssd_bcd_counter_mux
  import ssd_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_up_down,
  input  logic                  i_clear,
  output logic [4*DIGITS-1:0]   o_count_bcd,
  output logic                  o_wrap,
  output logic [6:0]            o_count_ssd,
  output logic [DIGITS-1:0]     o_digit_sel
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST   = PW'(PRESCALE - 1);
  localparam logic [RW-1:0]     REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST     = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_RESET    = ~DIGITS'(1);

  // Prescaler
  logic [PW-1:0] r_presc;
  logic          w_tick;

  // Counter
  bcd_digit_t [DIGITS-1:0] r_count;
  bcd_digit_t [DIGITS-1:0] w_count_step;
  logic                    w_roll;
  logic                    r_wrap;

  // Scan
  logic [RW-1:0] r_refresh;
  logic          w_refresh_end;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_next;

  // Display path
  logic [DIGITS-1:0] w_digit_sel_next;
  logic [DIGITS-1:0] r_digit_sel;
  bcd_digit_t        w_digit_mux;
  seg_t              w_dec_seg;
  logic [DIGITS-1:0] w_blank;
  logic              w_blank_sel;
  seg_t              w_ssd_next;
  seg_t              r_ssd;

  assign w_tick        = (r_presc == PRESC_LAST);
  assign w_refresh_end = (r_refresh == REFRESH_LAST);

  // Free-running prescaler; clear realigns it so the next tick is PRESCALE clocks away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (i_clear || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // BCD +/-1 with ripple carry/borrow; w_roll ends high only when every digit rolled.
  always_comb begin
    w_roll = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_count_step[i] = r_count[i];
      if (w_roll) begin
        if (i_up_down) begin
          if (r_count[i] >= 4'd9) begin
            w_count_step[i] = 4'd0;
          end else begin
            w_count_step[i] = r_count[i] + 4'd1;
            w_roll          = 1'b0;
          end
        end else begin
          if (r_count[i] == 4'd0) begin
            w_count_step[i] = 4'd9;
          end else begin
            w_count_step[i] = r_count[i] - 4'd1;
            w_roll          = 1'b0;
          end
        end
      end
    end
  end

  // Count register and one-cycle wrap pulse; clear beats a coincident tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (w_tick && i_enable) begin
      r_count <= w_count_step;
      r_wrap  <= w_roll;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Refresh counter sets how long each digit stays selected.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_refresh <= '0;
    end else if (w_refresh_end) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Next scan index; a single-digit display never moves.
  always_comb begin
    w_idx_next = r_idx;
    if (DIGITS == 1) begin
      w_idx_next = '0;
    end else if (w_refresh_end) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Scan index register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_next;
    end
  end

  // Select the digit that will be shown after the edge and its one-cold anode vector.
  always_comb begin
    w_digit_mux      = '0;
    w_digit_sel_next = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_idx_next == IW'(i)) begin
        w_digit_mux         = r_count[i];
        w_digit_sel_next[i] = 1'b0;
      end
    end
  end

  ssd_decoder u_decoder (
    .i_digit (w_digit_mux),
    .o_seg   (w_dec_seg)
  );

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic w_zero_run;

  // Digit i>0 blanks when it and every higher digit are zero.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_count[i] == 4'd0);
      w_blank[i] = w_zero_run;
    end
  end
`else
  // Every digit is decoded, leading zeros included.
  always_comb begin
    w_blank = '0;
  end
`endif

  assign w_blank_sel = |(w_blank & ~w_digit_sel_next);
  assign w_ssd_next  = w_blank_sel ? SEG_BLANK : w_dec_seg;

  // Segments and anodes registered together so they never disagree.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit_sel <= SEL_RESET;
      r_ssd       <= SEG_0;
    end else begin
      r_digit_sel <= w_digit_sel_next;
      r_ssd       <= w_ssd_next;
    end
  end

  assign o_count_bcd = r_count;
  assign o_wrap      = r_wrap;
  assign o_count_ssd = r_ssd;
  assign o_digit_sel = r_digit_sel;

endmodule

// File: tb/tb_ssd_bcd_counter_mux.sv
// Self-checking bench for ssd_bcd_counter_mux using several parameterisations
// on a shared clock and reset.
module tb_ssd_bcd_counter_mux;

  logic clk;
  logic rst_n;

  // DIGITS=2, PRESCALE=1
  logic       en2, ud2, clr2;
  logic [7:0] cnt2;
  logic       wrap2;
  logic [6:0] ssd2;
  logic [1:0] sel2;

  // DIGITS=4, PRESCALE=4
  logic        en4p, ud4p, clr4p;
  logic [15:0] cnt4p;
  logic        wrap4p;
  logic [6:0]  ssd4p;
  logic [3:0]  sel4p;

  // DIGITS=4, PRESCALE=1, REFRESH_DIV=2 (scan tests)
  logic        en4s, ud4s, clr4s;
  logic [15:0] cnt4s;
  logic        wrap4s;
  logic [6:0]  ssd4s;
  logic [3:0]  sel4s;

  // DIGITS=1
  logic       en1, ud1, clr1;
  logic [3:0] cnt1;
  logic       wrap1;
  logic [6:0] ssd1;
  logic [0:0] sel1;

  int n_vec;
  int n_err;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  ssd_bcd_counter_mux #(.DIGITS(2), .PRESCALE(1), .REFRESH_DIV(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en2), .i_up_down(ud2), .i_clear(clr2),
    .o_count_bcd(cnt2), .o_wrap(wrap2), .o_count_ssd(ssd2), .o_digit_sel(sel2)
  );

  ssd_bcd_counter_mux #(.DIGITS(4), .PRESCALE(4), .REFRESH_DIV(2)) u_dut4p (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en4p), .i_up_down(ud4p), .i_clear(clr4p),
    .o_count_bcd(cnt4p), .o_wrap(wrap4p), .o_count_ssd(ssd4p), .o_digit_sel(sel4p)
  );

  ssd_bcd_counter_mux #(.DIGITS(4), .PRESCALE(1), .REFRESH_DIV(2)) u_dut4s (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en4s), .i_up_down(ud4s), .i_clear(clr4s),
    .o_count_bcd(cnt4s), .o_wrap(wrap4s), .o_count_ssd(ssd4s), .o_digit_sel(sel4s)
  );

  ssd_bcd_counter_mux #(.DIGITS(1), .PRESCALE(1), .REFRESH_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1), .i_up_down(ud1), .i_clear(clr1),
    .o_count_bcd(cnt1), .o_wrap(wrap1), .o_count_ssd(ssd1), .o_digit_sel(sel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic       en;
    logic       ud;
    logic       clr;
    int         cycles;
    logic [7:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[12];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Align to the first cycle of the digit-0 window, then check all four windows.
  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [3:0] prev;
    bit         found;
    logic [6:0] exp_seg[4];
    logic [3:0] exp_sel;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      prev = sel4s;
      tick(1);
      if (sel4s == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s sync: DIGIT_SEL got %b, required entry into 1110", tag, sel4s);
    end else begin
      for (int d = 0; d < 4; d++) begin
        exp_sel = ~(4'b0001 << d);
        chk($sformatf("%s sel%0d", tag, d), 32'(sel4s), 32'(exp_sel));
        chk($sformatf("%s ssd%0d", tag, d), 32'(ssd4s), 32'(exp_seg[d]));
        tick(2);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {en2, ud2, clr2}    = 3'b000;
    {en4p, ud4p, clr4p} = 3'b000;
    {en4s, ud4s, clr4s} = 3'b000;
    {en1, ud1, clr1}    = 3'b000;

    //          en    ud    clr   cyc count  wrap
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 9,  8'h09, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1,  8'h10, 1'b0};  // carry 09 -> 10
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1,  8'h09, 1'b0};  // borrow 10 -> 09
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 90, 8'h99, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1,  8'h00, 1'b1};  // up wrap
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1,  8'h01, 1'b0};  // wrap lasts one cycle
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2,  8'h99, 1'b1};  // down wrap
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1,  8'h98, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 5,  8'h98, 1'b0};  // frozen
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1,  8'h99, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1,  8'h00, 1'b0};  // clear beats wrap
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3,  8'h03, 1'b0};

    // Reset state
    tick(2);
    chk("rst count4s", 32'(cnt4s), 32'h0);
    chk("rst wrap4s",  32'(wrap4s), 32'h0);
    chk("rst ssd4s",   32'(ssd4s), 32'(7'b1000000));
    chk("rst sel4s",   32'(sel4s), 32'(4'b1110));
    chk("rst sel2",    32'(sel2), 32'(2'b10));
    chk("rst sel1",    32'(sel1), 32'h0);
    rst_n = 1'b1;

    // Table-driven carry/borrow/wrap on the 2-digit counter
    for (int k = 0; k < 12; k++) begin
      en2  = vecs[k].en;
      ud2  = vecs[k].ud;
      clr2 = vecs[k].clr;
      tick(vecs[k].cycles);
      chk($sformatf("vec%0d count", k), 32'(cnt2), 32'(vecs[k].exp_count));
      chk($sformatf("vec%0d wrap", k), 32'(wrap2), 32'(vecs[k].exp_wrap));
    end
    {en2, ud2, clr2} = 3'b010;

    // Prescale = 4: one step per 4 clocks, clear on a tick, freeze, down wrap
    {en4p, ud4p, clr4p} = 3'b111;
    tick(1);
    clr4p = 1'b0;
    tick(3); chk("psc hold", 32'(cnt4p), 32'h0);
    tick(1); chk("psc step1", 32'(cnt4p), 32'h1);
    tick(4); chk("psc step2", 32'(cnt4p), 32'h2);
    tick(3);
    clr4p = 1'b1;
    tick(1); chk("clr on tick count", 32'(cnt4p), 32'h0);
    chk("clr on tick wrap", 32'(wrap4p), 32'h0);
    clr4p = 1'b0;
    tick(4); chk("psc after clr", 32'(cnt4p), 32'h1);
    en4p = 1'b0;
    tick(8); chk("enable freeze", 32'(cnt4p), 32'h1);
    en4p = 1'b1;
    ud4p = 1'b0;
    tick(4); chk("psc down", 32'(cnt4p), 32'h0);
    tick(4); chk("psc down wrap count", 32'(cnt4p), 32'h9999);
    chk("psc down wrap flag", 32'(wrap4p), 32'h1);
    tick(1); chk("psc wrap drop", 32'(wrap4p), 32'h0);
    chk("psc wrap hold", 32'(cnt4p), 32'h9999);
    en4p = 1'b0;

    // Single digit: constant anode, display lags count by one clock
    clr1 = 1'b1;
    tick(1);
    {en1, ud1, clr1} = 3'b110;
    tick(7);
    chk("d1 count", 32'(cnt1), 32'h7);
    chk("d1 ssd lag", 32'(ssd1), 32'(7'b0000010));
    chk("d1 sel", 32'(sel1), 32'h0);
    tick(3);
    chk("d1 wrap count", 32'(cnt1), 32'h0);
    chk("d1 wrap flag", 32'(wrap1), 32'h1);
    chk("d1 ssd9", 32'(ssd1), 32'(7'b0010000));
    chk("d1 sel2", 32'(sel1), 32'h0);
    en1 = 1'b0;

    // Scan with count 1234
    {en4s, ud4s, clr4s} = 3'b110;
    tick(1234);
    en4s = 1'b0;
    chk("scan count", 32'(cnt4s), 32'h1234);
    scan_check("s1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    // Leading zeros: 0007 then 0000
    clr4s = 1'b1;
    tick(1);
    clr4s = 1'b0;
    en4s  = 1'b1;
    tick(7);
    en4s  = 1'b0;
    chk("lz count", 32'(cnt4s), 32'h0007);
    scan_check("s0007", 7'b1111000, LZ, LZ, LZ);
    clr4s = 1'b1;
    tick(1);
    clr4s = 1'b0;
    scan_check("s0000", 7'b1000000, LZ, LZ, LZ);

    // Asynchronous reset between edges
    en2 = 1'b1;
    tick(3);
    en2 = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst cnt2", 32'(cnt2), 32'h0);
    chk("async rst cnt4p", 32'(cnt4p), 32'h0);
    chk("async rst sel4s", 32'(sel4s), 32'(4'b1110));
    chk("async rst ssd4s", 32'(ssd4s), 32'(7'b1000000));

    // First tick arrives PRESCALE clocks after release
    {en4p, ud4p, clr4p} = 3'b110;
    tick(1);
    rst_n = 1'b1;
    tick(3); chk("release hold", 32'(cnt4p), 32'h0);
    tick(1); chk("release first tick", 32'(cnt4p), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
